// File: rtl/stream_prefetch_wb.sv
// -----------------------------------------------------------------------------
// stream_prefetch_wb
//
// Read-only, fully-associative line buffer between the L1 miss path (CPU-side
// Wishbone slave) and physical memory (memory-side Wishbone master). Holds
// ENTRIES lines of 128 bits tagged by 12-bit line address. Writes are passed
// through to memory and invalidate any resident copy. After every demand miss
// a sequential prefetcher fetches up to PF_DEPTH following lines, never
// crossing a PAGE_LINES boundary.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cpu_adr_i             CPU line address
//   cpu_dat_i/cpu_dat_o   CPU write data (DAT_M) / read data (DAT_S)
//   cpu_sel_i             CPU byte selects (forwarded on writes only)
//   cpu_cyc_i/stb_i/we_i  CPU cycle, strobe, write enable
//   cpu_ack_o/cpu_rty_o   CPU acknowledge / retry (retry never asserted)
//   wb_adr_o/wb_dat_o     memory address / write data
//   wb_dat_i              memory read data
//   wb_sel_o              memory byte selects
//   wb_cyc_o/stb_o/we_o   memory cycle, strobe, write enable
//   wb_ack_i/wb_rty_i     memory acknowledge / retry
// -----------------------------------------------------------------------------
module stream_prefetch_wb #(
  parameter int ENTRIES    = 4,
  parameter int PF_DEPTH   = 2,
  parameter int PAGE_LINES = 256
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [11:0]  cpu_adr_i,
  input  logic [127:0] cpu_dat_i,
  output logic [127:0] cpu_dat_o,
  input  logic [15:0]  cpu_sel_i,
  input  logic         cpu_cyc_i,
  input  logic         cpu_stb_i,
  input  logic         cpu_we_i,
  output logic         cpu_ack_o,
  output logic         cpu_rty_o,
  output logic [11:0]  wb_adr_o,
  output logic [127:0] wb_dat_o,
  input  logic [127:0] wb_dat_i,
  output logic [15:0]  wb_sel_o,
  output logic         wb_cyc_o,
  output logic         wb_stb_o,
  output logic         wb_we_o,
  input  logic         wb_ack_i,
  input  logic         wb_rty_i
);

  localparam int IW = $clog2(ENTRIES);
  localparam int CW = (PF_DEPTH < 1) ? 1 : $clog2(PF_DEPTH + 1);
  localparam logic [11:0] PAGE_MASK = 12'(PAGE_LINES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RESP     = 3'd1,
    FILL     = 3'd2,
    WRITE    = 3'd3,
    PREFETCH = 3'd4
  } state_e;

  // True when a line address is the first line of a page; the 12-bit wrap to
  // 0x000 is also caught because 0x000 is always a page start.
  function automatic logic page_start(input logic [11:0] adr);
    return (adr & PAGE_MASK) == 12'h000;
  endfunction

  state_e          state_q, state_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic [127:0]    cpu_dat_q, cpu_dat_d;
  logic            wb_cyc_q, wb_cyc_d;
  logic            wb_stb_q, wb_stb_d;
  logic            wb_we_q, wb_we_d;
  logic [11:0]     wb_adr_q, wb_adr_d;
  logic [127:0]    wb_dat_q, wb_dat_d;
  logic [15:0]     wb_sel_q, wb_sel_d;
  logic [11:0]     pf_next_q, pf_next_d;
  logic [CW-1:0]   pf_count_q, pf_count_d;
  logic [IW-1:0]   rr_q, rr_d;

  logic [ENTRIES-1:0] valid_q;
  logic [11:0]        tag_q  [ENTRIES];
  logic [127:0]       data_q [ENTRIES];

  logic            cpu_hit_s;
  logic            pf_hit_s;
  logic [127:0]    hit_data_s;
  logic            any_inv_s;
  logic [IW-1:0]   vic_idx_s;
  logic            fill_en_s;
  logic            inv_en_s;
  logic [11:0]     pf_succ_s;
  logic [11:0]     fill_succ_s;

  assign pf_succ_s   = pf_next_q + 12'd1;
  assign fill_succ_s = wb_adr_q + 12'd1;

  assign cpu_ack_o = cpu_ack_q;
  assign cpu_dat_o = cpu_dat_q;
  assign cpu_rty_o = 1'b0;
  assign wb_cyc_o  = wb_cyc_q;
  assign wb_stb_o  = wb_stb_q;
  assign wb_we_o   = wb_we_q;
  assign wb_adr_o  = wb_adr_q;
  assign wb_dat_o  = wb_dat_q;
  assign wb_sel_o  = wb_sel_q;

  // Tag lookup for the CPU address and the prefetch candidate, plus victim pick.
  always_comb begin
    cpu_hit_s  = 1'b0;
    pf_hit_s   = 1'b0;
    hit_data_s = 128'h0;
    any_inv_s  = 1'b0;
    vic_idx_s  = rr_q;
    // Descending scan so the lowest invalid index is the last one written.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        any_inv_s = 1'b1;
        vic_idx_s = IW'(i);
      end else begin
      end
    end
    // Tags are unique, so OR-ing the matching lines yields the single hit line.
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == cpu_adr_i)) begin
        cpu_hit_s  = 1'b1;
        hit_data_s = hit_data_s | data_q[i];
      end else begin
      end
      if (valid_q[i] && (tag_q[i] == pf_next_q)) begin
        pf_hit_s = 1'b1;
      end else begin
      end
    end
  end

  // Next-state and registered-output logic for the controller.
  always_comb begin
    state_d    = state_q;
    cpu_ack_d  = cpu_ack_q;
    cpu_dat_d  = cpu_dat_q;
    wb_cyc_d   = wb_cyc_q;
    wb_stb_d   = wb_stb_q;
    wb_we_d    = wb_we_q;
    wb_adr_d   = wb_adr_q;
    wb_dat_d   = wb_dat_q;
    wb_sel_d   = wb_sel_q;
    pf_next_d  = pf_next_q;
    pf_count_d = pf_count_q;
    rr_d       = rr_q;
    fill_en_s  = 1'b0;
    inv_en_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_cyc_i && cpu_stb_i) begin
          if (cpu_we_i) begin
            state_d  = WRITE;
            wb_cyc_d = 1'b1;
            wb_stb_d = 1'b1;
            wb_we_d  = 1'b1;
            wb_adr_d = cpu_adr_i;
            wb_dat_d = cpu_dat_i;
            wb_sel_d = cpu_sel_i;
          end else if (cpu_hit_s) begin
            state_d   = RESP;
            cpu_dat_d = hit_data_s;
            cpu_ack_d = 1'b1;
          end else begin
            state_d  = FILL;
            wb_cyc_d = 1'b1;
            wb_stb_d = 1'b1;
            wb_we_d  = 1'b0;
            wb_adr_d = cpu_adr_i;
            wb_dat_d = 128'h0;
            wb_sel_d = 16'hFFFF;
          end
        end else if (pf_count_q != {CW{1'b0}}) begin
          if (pf_hit_s) begin
            // Already resident: step past it without a bus cycle.
            pf_next_d = pf_succ_s;
            if (page_start(pf_succ_s)) begin
              pf_count_d = {CW{1'b0}};
            end else begin
              pf_count_d = pf_count_q - CW'(1);
            end
          end else begin
            state_d  = PREFETCH;
            wb_cyc_d = 1'b1;
            wb_stb_d = 1'b1;
            wb_we_d  = 1'b0;
            wb_adr_d = pf_next_q;
            wb_dat_d = 128'h0;
            wb_sel_d = 16'hFFFF;
          end
        end else begin
        end
      end

      FILL, WRITE, PREFETCH: begin
        if (!wb_cyc_q) begin
          // Only reachable after a memory retry: reissue the held request.
          wb_cyc_d = 1'b1;
          wb_stb_d = 1'b1;
        end else if (wb_ack_i) begin
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
          wb_we_d  = 1'b0;
          case (state_q)
            WRITE: begin
              inv_en_s  = 1'b1;
              cpu_ack_d = 1'b1;
              state_d   = RESP;
            end
            FILL: begin
              fill_en_s = 1'b1;
              cpu_dat_d = wb_dat_i;
              cpu_ack_d = 1'b1;
              pf_next_d = fill_succ_s;
              if (page_start(fill_succ_s)) begin
                pf_count_d = {CW{1'b0}};
              end else begin
                pf_count_d = CW'(PF_DEPTH);
              end
              state_d = RESP;
            end
            default: begin
              fill_en_s = 1'b1;
              pf_next_d = pf_succ_s;
              if (page_start(pf_succ_s)) begin
                pf_count_d = {CW{1'b0}};
              end else begin
                pf_count_d = pf_count_q - CW'(1);
              end
              state_d = IDLE;
            end
          endcase
          // The pointer only moves when it actually chose the victim.
          if (fill_en_s && !any_inv_s) begin
            rr_d = rr_q + IW'(1);
          end else begin
            rr_d = rr_q;
          end
        end else if (wb_rty_i) begin
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
        end else begin
        end
      end

      RESP: begin
        cpu_ack_d = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state and registered bus outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cpu_ack_q  <= 1'b0;
      cpu_dat_q  <= 128'h0;
      wb_cyc_q   <= 1'b0;
      wb_stb_q   <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_adr_q   <= 12'h000;
      wb_dat_q   <= 128'h0;
      wb_sel_q   <= 16'h0000;
      pf_next_q  <= 12'h000;
      pf_count_q <= {CW{1'b0}};
      rr_q       <= {IW{1'b0}};
    end else begin
      state_q    <= state_d;
      cpu_ack_q  <= cpu_ack_d;
      cpu_dat_q  <= cpu_dat_d;
      wb_cyc_q   <= wb_cyc_d;
      wb_stb_q   <= wb_stb_d;
      wb_we_q    <= wb_we_d;
      wb_adr_q   <= wb_adr_d;
      wb_dat_q   <= wb_dat_d;
      wb_sel_q   <= wb_sel_d;
      pf_next_q  <= pf_next_d;
      pf_count_q <= pf_count_d;
      rr_q       <= rr_d;
    end
  end

  // Valid bits: set on fill, cleared by a write-through to a resident line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= {ENTRIES{1'b0}};
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (fill_en_s && (vic_idx_s == IW'(i))) begin
          valid_q[i] <= 1'b1;
        end else if (inv_en_s && (tag_q[i] == wb_adr_q)) begin
          valid_q[i] <= 1'b0;
        end else begin
        end
      end
    end
  end

  // Line tag and data storage; contents are meaningless while invalid.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (fill_en_s && (vic_idx_s == IW'(i))) begin
        tag_q[i]  <= wb_adr_q;
        data_q[i] <= wb_dat_i;
      end else begin
      end
    end
  end

endmodule

// File: tb/tb_stream_prefetch_wb.sv
module tb_stream_prefetch_wb;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [11:0]  cpu_adr_i;
  logic [127:0] cpu_dat_i;
  logic [127:0] cpu_dat_o;
  logic [15:0]  cpu_sel_i;
  logic         cpu_cyc_i, cpu_stb_i, cpu_we_i;
  logic         cpu_ack_o, cpu_rty_o;
  logic [11:0]  wb_adr_o;
  logic [127:0] wb_dat_o;
  logic [127:0] wb_dat_i;
  logic [15:0]  wb_sel_o;
  logic         wb_cyc_o, wb_stb_o, wb_we_o;
  logic         wb_ack_i, wb_rty_i;

  stream_prefetch_wb #(.ENTRIES(4), .PF_DEPTH(2), .PAGE_LINES(256)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o),
    .cpu_sel_i(cpu_sel_i), .cpu_cyc_i(cpu_cyc_i), .cpu_stb_i(cpu_stb_i),
    .cpu_we_i(cpu_we_i), .cpu_ack_o(cpu_ack_o), .cpu_rty_o(cpu_rty_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i), .wb_rty_i(wb_rty_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  // Memory responder state and transaction log.
  logic [11:0]  log_adr [64];
  logic [15:0]  log_sel [64];
  logic         log_we  [64];
  logic [127:0] log_dat [64];
  int n_log = 0;
  int ack_cycle = 0;
  int cpu_ack_cycle = 0;
  int rty_cnt = 0;
  int gap_cnt = 0;
  logic rty_once = 1'b0;
  logic rty_watch = 1'b0;
  logic hold_ack = 1'b0;
  logic inject_ack = 1'b0;

  localparam logic [127:0] WDATA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  function automatic logic [127:0] line_of(input logic [11:0] a);
    return {8{4'hD, a}};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk_i) cyc_cnt++;

  // Memory model: one-cycle ACK/RTY pulses, responds on the first cycle of STB.
  always @(negedge clk_i) begin
    if (rty_watch) begin
      if (!wb_cyc_o) gap_cnt++;
      else rty_watch = 1'b0;
    end
    if (wb_ack_i || wb_rty_i) begin
      wb_ack_i = 1'b0;
      wb_rty_i = 1'b0;
    end else if (inject_ack) begin
      inject_ack = 1'b0;
      wb_ack_i = 1'b1;
    end else if (wb_cyc_o && wb_stb_o && !hold_ack) begin
      if (rty_once) begin
        rty_once  = 1'b0;
        wb_rty_i  = 1'b1;
        rty_watch = 1'b1;
        rty_cnt++;
      end else begin
        wb_ack_i  = 1'b1;
        wb_dat_i  = line_of(wb_adr_o);
        ack_cycle = cyc_cnt;
        if (n_log < 64) begin
          log_adr[n_log] = wb_adr_o;
          log_sel[n_log] = wb_sel_o;
          log_we[n_log]  = wb_we_o;
          log_dat[n_log] = wb_dat_o;
        end
        n_log++;
      end
    end
  end

  task automatic cpu_access(input logic we, input logic [11:0] a, input logic [127:0] wd,
                            input logic [15:0] sel, output logic [127:0] d, output int lat);
    @(negedge clk_i);
    cpu_adr_i = a; cpu_we_i = we; cpu_dat_i = wd; cpu_sel_i = sel;
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
    lat = -1;
    d = 128'h0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk_i); #1;
      if (cpu_ack_o) begin
        lat = i;
        d = cpu_dat_o;
        cpu_ack_cycle = cyc_cnt;
        break;
      end
    end
    @(negedge clk_i);
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; cpu_we_i = 1'b0;
  endtask

  task automatic cpu_read(input logic [11:0] a, output logic [127:0] d, output int lat);
    cpu_access(1'b0, a, 128'h0, 16'h0000, d, lat);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i); rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b0;
  endtask

  logic [127:0] d;
  int lat, base, base2;
  logic [11:0] a;

  initial begin
    rst_i = 1'b1; cpu_adr_i = 12'h000; cpu_dat_i = 128'h0; cpu_sel_i = 16'h0000;
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; cpu_we_i = 1'b0;
    wb_dat_i = 128'h0; wb_ack_i = 1'b0; wb_rty_i = 1'b0;
    repeat (3) @(posedge clk_i); #1;
    check_eq("rst_ctrl", {cpu_ack_o, cpu_rty_o, wb_cyc_o, wb_stb_o, wb_we_o}, 128'h0);
    check_eq("rst_bus", {wb_adr_o, wb_sel_o, wb_dat_o}, 128'h0);
    check_eq("rst_cpu_dat", cpu_dat_o, 128'h0);
    @(negedge clk_i); rst_i = 1'b0;

    // Cold miss, then hit on the same line.
    base = n_log;
    cpu_read(12'h010, d, lat);
    check_eq("miss010_data", d, line_of(12'h010));
    check_eq("miss010_lat", 128'(lat), 128'd2);
    check_eq("miss010_ackgap", 128'(cpu_ack_cycle - ack_cycle), 128'd1);
    check_eq("miss010_req", {log_we[base], log_sel[base], log_adr[base]}, {1'b0, 16'hFFFF, 12'h010});
    idle(10);
    check_eq("pf010_count", 128'(n_log - base), 128'd3);
    check_eq("pf010_adrs", {log_adr[base+1], log_adr[base+2]}, {12'h011, 12'h012});
    base = n_log;
    cpu_read(12'h010, d, lat);
    check_eq("hit010_lat", 128'(lat), 128'd1);
    check_eq("hit010_data", d, line_of(12'h010));
    check_eq("hit010_nobus", 128'(n_log - base), 128'd0);

    // Miss with two-line prefetch; prefetched lines then hit.
    base = n_log;
    cpu_read(12'h100, d, lat);
    idle(10);
    check_eq("pf100_count", 128'(n_log - base), 128'd3);
    check_eq("pf100_order", {log_adr[base], log_adr[base+1], log_adr[base+2]},
             {12'h100, 12'h101, 12'h102});
    cpu_read(12'h101, d, lat);
    check_eq("hit101_lat", 128'(lat), 128'd1);
    check_eq("hit101_data", d, line_of(12'h101));
    cpu_read(12'h102, d, lat);
    check_eq("hit102_lat", 128'(lat), 128'd1);
    check_eq("hit10x_nobus", 128'(n_log - base), 128'd3);

    // Page end and 12-bit wrap suppress prefetch.
    base = n_log;
    cpu_read(12'h0FF, d, lat);
    check_eq("miss0ff_lat", 128'(lat), 128'd2);
    idle(10);
    check_eq("page0ff_nopf", 128'(n_log - base), 128'd1);
    cpu_read(12'hFFF, d, lat);
    check_eq("missfff_data", d, line_of(12'hFFF));
    idle(10);
    check_eq("wrapfff_nopf", 128'(n_log - base), 128'd2);

    // Write-through invalidates a resident line; refetch skips resident 0x102.
    base = n_log;
    cpu_access(1'b1, 12'h101, WDATA, 16'h00FF, d, lat);
    check_eq("wr101_lat", 128'(lat), 128'd2);
    check_eq("wr101_ackgap", 128'(cpu_ack_cycle - ack_cycle), 128'd1);
    check_eq("wr101_req", {log_we[base], log_sel[base], log_adr[base]}, {1'b1, 16'h00FF, 12'h101});
    check_eq("wr101_dat", log_dat[base], WDATA);
    cpu_read(12'h101, d, lat);
    check_eq("rd101_miss_lat", 128'(lat), 128'd2);
    check_eq("rd101_data", d, line_of(12'h101));
    idle(10);
    check_eq("rd101_bus_count", 128'(n_log - base), 128'd3);
    check_eq("rd101_skip_pf", {log_adr[base+1], log_adr[base+2]}, {12'h101, 12'h103});

    // Memory retry on a fill.
    base = n_log;
    gap_cnt = 0;
    rty_once = 1'b1;
    cpu_read(12'h200, d, lat);
    check_eq("rty_data", d, line_of(12'h200));
    check_eq("rty_gap", 128'(gap_cnt), 128'd1);
    check_eq("rty_reissue", {log_we[base], log_sel[base], log_adr[base]}, {1'b0, 16'hFFFF, 12'h200});
    check_eq("rty_count", 128'(rty_cnt), 128'd1);
    idle(10);

    // Replacement order from a clean buffer, page-end lines so no prefetch.
    do_reset();
    base = n_log;
    for (int i = 0; i < 6; i++) begin
      a = 12'h0FF + 12'(i * 256);
      cpu_read(a, d, lat);
    end
    idle(10);
    check_eq("evict_fills", 128'(n_log - base), 128'd6);
    base2 = n_log;
    for (int i = 2; i < 6; i++) begin
      a = 12'h0FF + 12'(i * 256);
      cpu_read(a, d, lat);
      check_eq($sformatf("evict_hit_%0h", a), 128'(lat), 128'd1);
    end
    check_eq("evict_hits_nobus", 128'(n_log - base2), 128'd0);
    cpu_read(12'h0FF, d, lat);
    check_eq("evict_0ff_miss", 128'(n_log - base2), 128'd1);

    // Reset in the middle of a fill, then a stray late ACK.
    base = n_log;
    hold_ack = 1'b1;
    @(negedge clk_i);
    cpu_adr_i = 12'h300; cpu_we_i = 1'b0; cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      if (wb_cyc_o) break;
    end
    check_eq("fill300_started", 128'(wb_cyc_o), 128'd1);
    idle(2);
    @(negedge clk_i);
    rst_i = 1'b1; cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0;
    @(posedge clk_i); #1;
    check_eq("midrst_ctrl", {cpu_ack_o, wb_cyc_o, wb_stb_o, wb_we_o}, 128'h0);
    check_eq("midrst_bus", {wb_adr_o, wb_sel_o, wb_dat_o}, 128'h0);
    check_eq("midrst_cpu_dat", cpu_dat_o, 128'h0);
    @(negedge clk_i);
    rst_i = 1'b0; hold_ack = 1'b0;
    #1 inject_ack = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("late_ack_ignored", {cpu_ack_o, wb_cyc_o}, 128'h0);
    check_eq("late_ack_nolog", 128'(n_log - base), 128'd0);
    cpu_read(12'h300, d, lat);
    check_eq("rd300_miss_lat", 128'(lat), 128'd2);
    check_eq("rd300_data", d, line_of(12'h300));
    check_eq("rd300_adr", log_adr[base], 128'h300);
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
